// File: rtl/finalizer_rom_loader.sv
// Routes the index-0 download stream into four ROM regions, validates order/length, sums the bytes,
// captures header and DIP bytes, and holds the core in reset until a complete ROM set is loaded.
`timescale 1ns/1ps
module finalizer_rom_loader #(
  parameter logic [17:0] R0_LEN = 18'h10000,
  parameter logic [17:0] R1_LEN = 18'h10000,
  parameter logic [17:0] R2_LEN = 18'h08000,
  parameter logic [17:0] R3_LEN = 18'h00400
) (
  input  logic        clk_49m,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [3:0]  rom_wr,
  output logic [17:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic [23:0] dip_sw,
  output logic [1:0]  is_bootleg,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] checksum
);

  localparam logic [24:0] B1    = 25'(R0_LEN);
  localparam logic [24:0] B2    = B1 + 25'(R1_LEN);
  localparam logic [24:0] B3    = B2 + 25'(R2_LEN);
  localparam logic [24:0] TOTAL = B3 + 25'(R3_LEN);

  typedef enum logic [1:0] {IDLE, LOADING, DONE, ERROR} state_t;

  state_t      state, state_nxt;
  logic        dl_prev, dl_rise, dl_fall;
  logic [24:0] count, count_nxt;
  logic        accept, restart;
  logic [1:0]  sel;
  logic [24:0] base;
  logic [17:0] rom_off;

  assign dl_rise = ioctl_download & ~dl_prev;
  assign dl_fall = ~ioctl_download & dl_prev;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    accept    = 1'b0;
    restart   = 1'b0;
    case (state)
      LOADING: begin
        if (ioctl_wr && ioctl_index == 8'd0) begin
          if (ioctl_addr != count || count >= TOTAL) begin
            state_nxt = ERROR;
          end else begin
            accept    = 1'b1;
            count_nxt = count + 25'd1;
          end
        end
        // A write landing on the falling edge is counted before the length check.
        if (dl_fall && state_nxt == LOADING)
          state_nxt = (count_nxt == TOTAL) ? DONE : ERROR;
      end
      default: begin
        if (dl_rise && ioctl_index == 8'd0) begin
          state_nxt = LOADING;
          count_nxt = '0;
          restart   = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    sel  = 2'd3;
    base = B3;
    if (ioctl_addr < B1) begin
      sel  = 2'd0;
      base = '0;
    end else if (ioctl_addr < B2) begin
      sel  = 2'd1;
      base = B1;
    end else if (ioctl_addr < B3) begin
      sel  = 2'd2;
      base = B2;
    end
  end

  assign rom_off = 18'(ioctl_addr - base);

  always_ff @(posedge clk_49m) begin
    if (reset) begin
      state      <= IDLE;
      dl_prev    <= 1'b0;
      count      <= '0;
      rom_wr     <= '0;
      rom_addr   <= '0;
      rom_data   <= '0;
      checksum   <= '0;
      dip_sw     <= 24'hFFFFFF;
      is_bootleg <= '0;
    end else begin
      state   <= state_nxt;
      dl_prev <= ioctl_download;
      count   <= count_nxt;
      rom_wr  <= '0;
      if (accept) begin
        rom_wr   <= 4'b0001 << sel;
        rom_addr <= rom_off;
        rom_data <= ioctl_dout;
        checksum <= checksum + 16'(ioctl_dout);
      end else if (restart) begin
        checksum <= '0;
      end
      if (ioctl_wr && ioctl_index == 8'd1 && ioctl_addr == 25'd0)
        is_bootleg <= ioctl_dout[1:0];
      if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < 25'd3) begin
        case (ioctl_addr[1:0])
          2'd0:    dip_sw[7:0]   <= ioctl_dout;
          2'd1:    dip_sw[15:8]  <= ioctl_dout;
          default: dip_sw[23:16] <= ioctl_dout;
        endcase
      end
    end
  end

  assign load_done  = (state == DONE);
  assign load_error = (state == ERROR);
  assign cpu_hold   = (state != DONE);

endmodule

// File: tb/tb_finalizer_rom_loader.sv
// Randomized bench for finalizer_rom_loader with a byte-level reference model and strobe scoreboard.
// Region sizes are scaled down by 256 so full loads stay short.
`timescale 1ns/1ps
module tb_finalizer_rom_loader;

  localparam logic [17:0] L0 = 18'h00100;
  localparam logic [17:0] L1 = 18'h00100;
  localparam logic [17:0] L2 = 18'h00080;
  localparam logic [17:0] L3 = 18'h00004;
  localparam int TOTAL = int'(L0) + int'(L1) + int'(L2) + int'(L3);

  logic        clk_49m = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [3:0]  rom_wr;
  logic [17:0] rom_addr;
  logic [7:0]  rom_data;
  logic [23:0] dip_sw;
  logic [1:0]  is_bootleg;
  logic        cpu_hold, load_done, load_error;
  logic [15:0] checksum;

  finalizer_rom_loader #(.R0_LEN(L0), .R1_LEN(L1), .R2_LEN(L2), .R3_LEN(L3)) dut (
    .clk_49m(clk_49m), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .rom_wr(rom_wr), .rom_addr(rom_addr), .rom_data(rom_data),
    .dip_sw(dip_sw), .is_bootleg(is_bootleg), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_error(load_error), .checksum(checksum)
  );

  always #10 clk_49m = ~clk_49m;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 loading, 2 done, 3 error.
  int          m_phase, m_cnt;
  logic [15:0] m_sum;
  logic [23:0] m_dip;
  logic [1:0]  m_boot;
  logic [29:0] sb[$];
  int          lens[4] = '{int'(L0), int'(L1), int'(L2), int'(L3)};

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_sum = '0; m_dip = 24'hFFFFFF; m_boot = '0;
  endtask

  function automatic logic [29:0] expect_strobe(input int addr, input logic [7:0] d);
    int base = 0;
    for (int r = 0; r < 4; r++) begin
      if (addr < base + lens[r] || r == 3)
        return {4'(1 << r), 18'(addr - base), d};
      base += lens[r];
    end
    return '0;
  endfunction

  task automatic tick();
    @(posedge clk_49m);
    #1;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    if (idx == 8'd0 && m_phase != 1) begin
      m_phase = 1; m_cnt = 0; m_sum = '0;
    end
    tick(); tick();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    if (m_phase == 1) m_phase = (m_cnt == TOTAL) ? 2 : 3;
    tick(); tick(); tick();
  endtask

  task automatic wr_byte(input int addr, input logic [7:0] d);
    ioctl_addr = 25'(addr);
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    if (ioctl_index == 8'd0 && m_phase == 1) begin
      if (addr == m_cnt && m_cnt < TOTAL) begin
        sb.push_back(expect_strobe(addr, d));
        m_cnt++;
        m_sum = m_sum + 16'(d);
      end else begin
        m_phase = 3;
      end
    end else if (ioctl_index == 8'd1 && addr == 0) begin
      m_boot = d[1:0];
    end else if (ioctl_index == 8'd254 && addr < 3) begin
      m_dip[8*addr +: 8] = d;
    end
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic load_seq(input int first, input int n);
    for (int a = first; a < first + n; a++) begin
      wr_byte(a, 8'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".done"}, 32'(load_done), 32'(m_phase == 2));
    chk({tag, ".error"}, 32'(load_error), 32'(m_phase == 3));
    chk({tag, ".hold"}, 32'(cpu_hold), 32'(m_phase != 2));
    chk({tag, ".sum"}, 32'(checksum), 32'(m_sum));
    chk({tag, ".dip"}, 32'(dip_sw), 32'(m_dip));
    chk({tag, ".boot"}, 32'(is_bootleg), 32'(m_boot));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_index = 8'd0;
    model_reset();
    tick();
    chk("rst.rom_wr", 32'(rom_wr), 0);
    chk("rst.rom_addr", 32'(rom_addr), 0);
    chk("rst.rom_data", 32'(rom_data), 0);
    check_all("rst");
    reset = 1'b0;
    tick();
  endtask

  logic [29:0] sb_e;
  always @(negedge clk_49m) begin
    if (!reset && rom_wr !== 4'b0000) begin
      if (sb.size() == 0) begin
        chk("spurious_wr", 32'(rom_wr), 0);
      end else begin
        sb_e = sb.pop_front();
        chk("wr_sel", 32'(rom_wr), 32'(sb_e[29:26]));
        chk("wr_addr", 32'(rom_addr), 32'(sb_e[25:8]));
        chk("wr_data", 32'(rom_data), 32'(sb_e[7:0]));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    tick();
    do_reset();

    // Full ordered load crossing every region boundary.
    start_dl(8'd0);
    check_all("full.start");
    load_seq(0, TOTAL);
    end_dl();
    check_all("full.end");

    // DIP and header downloads leave the load state alone.
    start_dl(8'd254);
    wr_byte(0, 8'hA5); wr_byte(1, 8'h3C); wr_byte(2, 8'h0F); wr_byte(3, 8'h77);
    end_dl();
    chk("dip.value", 32'(dip_sw), 32'h0F3CA5);
    check_all("dip");
    start_dl(8'd1);
    wr_byte(0, 8'h02); wr_byte(1, 8'h03);
    end_dl();
    chk("boot.value", 32'(is_bootleg), 2);
    check_all("hdr");

    // Short load: stream ends early.
    start_dl(8'd0);
    check_all("short.start");
    load_seq(0, int'(L0) + int'(L1));
    end_dl();
    check_all("short.end");

    // Address skip errors on the same cycle as the bad write.
    start_dl(8'd0);
    load_seq(0, 4);
    wr_byte(5, 8'($urandom));
    check_all("skip.write");
    wr_byte(6, 8'($urandom));
    end_dl();
    check_all("skip.end");

    // Overflow: one byte beyond the full set.
    start_dl(8'd0);
    load_seq(0, TOTAL);
    wr_byte(TOTAL, 8'($urandom));
    check_all("ovf.write");
    end_dl();
    check_all("ovf.end");

    // Reset mid-load, then a clean reload.
    start_dl(8'd0);
    load_seq(0, 8'h12);
    do_reset();
    start_dl(8'd0);
    load_seq(0, TOTAL);
    end_dl();
    check_all("reload.end");

    repeat (3) tick();
    chk("sb_drain", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
